// File: rtl/lsu_seq.sv
// Load/store sequencer: takes one access from execute, runs the memory request/response
// handshake while stalling the pipeline, then returns extended load data or an exception.
module lsu_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        stall,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [63:0] exc_addr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d, exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;

  logic        accept, illegal, misal, timeout_hit;
  logic [5:0]  sh;
  logic [63:0] rsp_shifted;

  assign accept      = (state_q == IDLE) && ex_valid && (ex_is_load || ex_is_store);
  assign illegal     = (ex_is_load && ex_is_store) || (ex_is_load && ex_funct3 == 3'd7) ||
                       (ex_is_store && ex_funct3[2]);
  assign sh          = {addr_q[2:0], 3'b000};
  assign rsp_shifted = mem_rsp_rdata >> sh;
  // The last counted REQ/WAIT cycle already belongs to the timeout: request drops, response ignored.
  assign timeout_hit = (state_q == REQ || state_q == WAIT) && (timer_q == TO_LAST);

  always_comb begin
    misal = 1'b0;
    case (ex_funct3[1:0])
      2'd0: misal = 1'b0;
      2'd1: misal = ex_addr[0];
      2'd2: misal = |ex_addr[1:0];
      default: misal = |ex_addr[2:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    load_d  = load_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = ex_addr;
        wdata_d = ex_wdata;
        f3_d    = ex_funct3;
        rd_d    = ex_rd;
        load_d  = ex_is_load && !ex_is_store;
        timer_d = 16'd0;
        exc_d   = illegal || misal;
        cause_d = illegal ? 2'd3 : (ex_is_load ? 2'd0 : 2'd1);
        state_d = (illegal || misal) ? DONE : REQ;
      end
      REQ: begin
        timer_d = timer_q + 16'd1;
        if (timeout_hit) begin
          exc_d   = 1'b1;
          cause_d = 2'd2;
          state_d = DONE;
        end else if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            data_d  = rsp_shifted;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        timer_d = timer_q + 16'd1;
        if (timeout_hit) begin
          exc_d   = 1'b1;
          cause_d = 2'd2;
          state_d = DONE;
        end else if (mem_rsp_valid) begin
          data_d  = rsp_shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    ex_ready      = (state_q == IDLE);
    stall         = (state_q != IDLE);
    mem_req_valid = (state_q == REQ) && !timeout_hit;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if (mem_req_valid) begin
      mem_req_we    = !load_q;
      mem_req_addr  = {addr_q[63:3], 3'b000};
      mem_req_wdata = wdata_q << sh;
      if (!load_q) begin
        case (f3_q[1:0])
          2'd0: mem_req_wstrb = 8'(8'h01 << addr_q[2:0]);
          2'd1: mem_req_wstrb = 8'(8'h03 << addr_q[2:0]);
          2'd2: mem_req_wstrb = 8'(8'h0F << addr_q[2:0]);
          default: mem_req_wstrb = 8'hFF;
        endcase
      end
    end
  end

  always_comb begin
    wb_valid  = (state_q == DONE) && load_q && !exc_q;
    exc_valid = (state_q == DONE) && exc_q;
    wb_rd     = '0;
    wb_data   = '0;
    exc_cause = '0;
    exc_addr  = '0;
    if (wb_valid) begin
      wb_rd = rd_q;
      case (f3_q)
        3'd0: wb_data = {{56{data_q[7]}},  data_q[7:0]};
        3'd1: wb_data = {{48{data_q[15]}}, data_q[15:0]};
        3'd2: wb_data = {{32{data_q[31]}}, data_q[31:0]};
        3'd4: wb_data = {56'd0, data_q[7:0]};
        3'd5: wb_data = {48'd0, data_q[15:0]};
        3'd6: wb_data = {32'd0, data_q[31:0]};
        default: wb_data = data_q;
      endcase
    end
    if (exc_valid) begin
      exc_cause = cause_q;
      exc_addr  = addr_q;
    end
  end
endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: loads of every width, stores, exceptions, timeout and reset abort.
module tb_lsu_seq;
  logic        clk, rst;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        stall, exc_valid;
  logic [1:0]  exc_cause;
  logic [63:0] exc_addr;

  int checks = 0;
  int errors = 0;

  lsu_seq #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    chk("acc_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  // Ready in the first REQ cycle, response in the following cycle: wb three cycles after accept.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [4:0] rd, input logic [63:0] exp);
    issue(1'b1, 1'b0, f3, addr, 64'd0, rd);
    chk({tag, "_rv"}, mem_req_valid, 1);
    chk({tag, "_ra"}, mem_req_addr, {addr[63:3], 3'b000});
    chk({tag, "_rs"}, {mem_req_we, mem_req_wstrb}, 9'h000);
    mem_req_ready = 1'b1;
    step();
    chk({tag, "_w0"}, {wb_valid, mem_req_valid, stall}, 3'b001);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    step();
    mem_rsp_valid = 1'b0;
    chk({tag, "_wv"}, {wb_valid, exc_valid}, 2'b10);
    chk({tag, "_wd"}, wb_data, exp);
    chk({tag, "_rd"}, wb_rd, rd);
    step();
    chk({tag, "_end"}, {wb_valid, ex_ready, stall}, 3'b010);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [7:0] strb, input logic [63:0] wexp);
    issue(1'b0, 1'b1, f3, addr, wd, 5'd0);
    for (int c = 0; c < 2; c++) begin
      chk({tag, "_rv"}, {mem_req_valid, mem_req_we}, 2'b11);
      chk({tag, "_ra"}, mem_req_addr, {addr[63:3], 3'b000});
      chk({tag, "_st"}, mem_req_wstrb, strb);
      chk({tag, "_wd"}, mem_req_wdata, wexp);
      mem_req_ready = (c == 1); mem_rsp_valid = (c == 1);
      step();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk({tag, "_dn"}, {wb_valid, exc_valid, stall, mem_req_valid}, 4'b0010);
    step();
    chk({tag, "_end"}, {ex_ready, stall}, 2'b10);
  endtask

  task automatic run_exc(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [1:0] cause);
    issue(ld, st, f3, addr, 64'h1234, 5'd3);
    chk({tag, "_ev"}, {exc_valid, wb_valid, mem_req_valid}, 3'b100);
    chk({tag, "_ec"}, exc_cause, cause);
    chk({tag, "_ea"}, exc_addr, addr);
    step();
    chk({tag, "_end"}, {exc_valid, ex_ready}, 2'b01);
  endtask

  initial begin
    int n;
    rst = 1'b1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    #3;
    chk("rst_ctl", {ex_ready, stall, mem_req_valid, wb_valid, exc_valid}, 5'b10000);
    chk("rst_dat", wb_data | exc_addr | mem_req_addr | mem_req_wdata, 0);
    step();
    rst = 1'b0;
    step();

    run_load("lb",  3'd0, 64'h1003, 64'h00000000_80FF0000, 5'd5,  64'hFFFFFFFF_FFFFFF80);
    run_load("lbu", 3'd4, 64'h1003, 64'h00000000_80FF0000, 5'd6,  64'h00000000_00000080);
    run_load("lwu", 3'd6, 64'h1004, 64'h89ABCDEF_00000000, 5'd7,  64'h00000000_89ABCDEF);
    run_load("lw",  3'd2, 64'h1004, 64'h89ABCDEF_00000000, 5'd8,  64'hFFFFFFFF_89ABCDEF);
    run_load("lh",  3'd1, 64'h1002, 64'h00000000_80010000, 5'd9,  64'hFFFFFFFF_FFFF8001);
    run_load("lhu", 3'd5, 64'h1002, 64'h00000000_80010000, 5'd10, 64'h00000000_00008001);
    run_load("ld",  3'd3, 64'h1008, 64'h01234567_89ABCDEF, 5'd11, 64'h01234567_89ABCDEF);

    run_store("sh", 3'd1, 64'h2006, 64'hBEEF, 8'hC0, 64'hBEEF0000_00000000);
    run_store("sb", 3'd0, 64'h2005, 64'hA5,   8'h20, 64'h0000A500_00000000);
    run_store("sw", 3'd2, 64'h2004, 64'h11223344, 8'hF0, 64'h11223344_00000000);
    run_store("sd", 3'd3, 64'h2008, 64'hCAFEF00D_12345678, 8'hFF, 64'hCAFEF00D_12345678);

    run_exc("ldmis", 1'b1, 1'b0, 3'd3, 64'h3004, 2'd0);
    run_exc("lhmis", 1'b1, 1'b0, 3'd5, 64'h3001, 2'd0);
    run_exc("swmis", 1'b0, 1'b1, 3'd2, 64'h3002, 2'd1);
    run_exc("sf3",   1'b0, 1'b1, 3'd4, 64'h3000, 2'd3);
    run_exc("lf3",   1'b1, 1'b0, 3'd7, 64'h3000, 2'd3);
    run_exc("both",  1'b1, 1'b1, 3'd3, 64'h3001, 2'd3);

    // neither flag: not accepted
    ex_valid = 1'b1; ex_funct3 = 3'd3; ex_addr = 64'h3000;
    step();
    ex_valid = 1'b0;
    chk("noflag", {ex_ready, stall, mem_req_valid, exc_valid}, 4'b1000);

    // timeout with ready held low, then a late response, then a normal fast LD
    issue(1'b1, 1'b0, 3'd3, 64'h4000, 64'd0, 5'd12);
    n = 1;
    while (!exc_valid && n < 12) begin
      step();
      n++;
    end
    chk("to_lat", n, 5);
    chk("to_cause", {exc_valid, exc_cause, mem_req_valid, wb_valid}, 5'b11000);
    chk("to_addr", exc_addr, 64'h4000);
    step();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD;
    step();
    mem_rsp_valid = 1'b0;
    chk("to_late", {wb_valid, exc_valid, stall, ex_ready}, 4'b0001);
    issue(1'b1, 1'b0, 3'd3, 64'h4008, 64'd0, 5'd13);
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h55AA_55AA_0102_0304;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("fast_wv", wb_valid, 1);
    chk("fast_wd", wb_data, 64'h55AA_55AA_0102_0304);
    step();

    // reset during WAIT aborts; a later response must not write back
    issue(1'b1, 1'b0, 3'd3, 64'h5000, 64'd0, 5'd14);
    chk("ra_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("ra_wait", {stall, mem_req_valid}, 2'b10);
    #2 rst = 1'b1;
    #1 chk("ra_rst", {mem_req_valid, stall, ex_ready}, 3'b001);
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF;
    step();
    mem_rsp_valid = 1'b0;
    chk("ra_orph", {wb_valid, exc_valid, stall}, 3'b000);
    step();
    chk("ra_idle", {wb_valid, ex_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
